// File: rtl/ysyx_22051013_ifu_fetch_if.sv
// Fetch-stage bus: imem request/response, execute redirect and decode output buffer.
// The master modport is the fetch unit; slave is the surrounding pipeline/memory.
interface ysyx_22051013_ifu_fetch_if #(
    parameter int XLEN = 64,
    parameter int ILEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            inst_valid;
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_misalign;
    logic            id_ready;

    modport master (
        output imem_req_valid, imem_addr, inst_valid, inst, inst_pc, inst_misalign,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr, inst_valid, inst, inst_pc, inst_misalign,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/ysyx_22051013_ifu_fetch.sv
// Instruction fetch: one outstanding imem request, single-entry output buffer,
// redirects squash the buffer and kill any in-flight response.
module ysyx_22051013_ifu_fetch #(
    parameter int              XLEN     = 64,
    parameter int              ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic clk,
    input  logic rst,
    ysyx_22051013_ifu_fetch_if.master bus
);
    localparam logic [0:0] S_REQ  = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;
    localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

    logic [0:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            kill_q, kill_d;
    logic            inst_valid_q, inst_valid_d;
    logic [ILEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            misalign_q, misalign_d;
    logic            req_valid;

    // Request only when the buffer will have room at the next edge; never
    // depends on the response side.
    assign req_valid = (state_q == S_REQ) && (!inst_valid_q || bus.id_ready)
                       && !bus.redirect_valid && !rst;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_addr      = pc_q;
    assign bus.inst_valid     = inst_valid_q;
    assign bus.inst           = inst_q;
    assign bus.inst_pc        = inst_pc_q;
    assign bus.inst_misalign  = inst_valid_q & misalign_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        kill_d       = kill_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        misalign_d   = misalign_q;

        if (inst_valid_q && bus.id_ready) inst_valid_d = 1'b0;

        if (bus.redirect_valid) begin
            pc_d         = bus.redirect_pc;
            inst_valid_d = 1'b0;
            if (state_q == S_WAIT) begin
                if (bus.imem_rsp_valid) begin
                    kill_d  = 1'b0;
                    state_d = S_REQ;
                end else begin
                    kill_d  = 1'b1;
                end
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    if (req_valid && bus.imem_req_ready) state_d = S_WAIT;
                end
                default: begin
                    if (bus.imem_rsp_valid) begin
                        state_d = S_REQ;
                        if (kill_q) begin
                            kill_d = 1'b0;
                        end else begin
                            inst_d       = bus.imem_rsp_data;
                            inst_pc_d    = pc_q;
                            misalign_d   = |pc_q[1:0];
                            inst_valid_d = 1'b1;
                            pc_d         = pc_q + XLEN'(4);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            kill_q       <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= NOP;
            inst_pc_q    <= '0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            kill_q       <= kill_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            misalign_q   <= misalign_d;
        end
    end
endmodule
